lsu_ram_adapter: RTL

Load/store front-end for the byte-write data RAM. It accepts one memory request at a time from the core's load/store path over a valid/ready handshake and generates the RAM controls: byte-lane write enables, lane-replicated write data, and the byte address. It also consumes the RAM's 1-cycle-latency read port, extracting and sign/zero-extending byte, halfword and word loads. It sits directly upstream of the RAM and returns a registered response with backpressure.

---
 rtl/lsu_ram_adapter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lsu_ram_adapter.sv
// rtl/lsu_ram_adapter.sv - load/store front-end for the byte-write data RAM
// One request in flight; registered response with backpressure.
module lsu_ram_adapter #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_di,
  input  logic [31:0]           ram_dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LDATA = 2'd1;
  localparam logic [1:0] S_RSP   = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_bad;
  logic [3:0]  w_we;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // rstn gating keeps the RAM write-disabled while reset is held
  assign req_ready = (r_state == S_IDLE) && rstn;
  assign w_accept  = req_valid && req_ready;
  assign ram_addr  = req_addr;
  assign ram_we    = (w_accept && req_we && !w_bad) ? w_we : 4'b0000;
  assign rsp_valid = (r_state == S_RSP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_comb begin
    w_bad = 1'b0;
    case (req_size)
      2'b00:   w_bad = 1'b0;
      2'b01:   w_bad = req_addr[0];
      2'b10:   w_bad = |req_addr[1:0];
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_we   = 4'b0000;
    ram_di = req_wdata;
    case (req_size)
      2'b00: begin
        w_we   = 4'b0001 << req_addr[1:0];
        ram_di = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_we   = 4'b0011 << {req_addr[1], 1'b0};
        ram_di = {2{req_wdata[15:0]}};
      end
      2'b10:   w_we = 4'b1111;
      default: w_we = 4'b0000;
    endcase
  end

  // Lane select and extension of the RAM word returned during LDATA
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = ram_dout[7:0];
      2'd1:    w_byte = ram_dout[15:8];
      2'd2:    w_byte = ram_dout[23:16];
      default: w_byte = ram_dout[31:24];
    endcase
    w_half = r_lane[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (r_size)
      2'b00:   w_ext = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
      2'b01:   w_ext = {{16{w_half[15] & ~r_unsigned}}, w_half};
      default: w_ext = ram_dout;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_lane     <= 2'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_lane     <= req_addr[1:0];
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_rdata    <= 32'd0;
            r_err      <= w_bad;
            r_state    <= (!w_bad && !req_we) ? S_LDATA : S_RSP;
          end
        end
        S_LDATA: begin
          r_rdata <= w_ext;
          r_state <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
